mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencing controller for the memory stage and the MEM/WB pipeline latch. It issues read and write strobes to the multi-cycle data memory and freezes the upstream pipeline while an access is outstanding. It drives the MEM/WB `en` and `data_en` enables, and inserts bubbles so a stalled instruction writes back exactly once. It also detects access timeouts and illegal requests, and moves the machine to a halted state.

## Interface
- `TO_CYCLES`, 16: maximum number of cycles in WAIT before a timeout is declared (≥2).
- `CW`, 5: width of the wait counter; must satisfy 2^CW > TO_CYCLES.

- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; while low, all outputs are forced to 0.
- `memRead_XM`  in  1  instruction in EX/MEM performs a load.
- `memWrite_XM`  in  1  instruction in EX/MEM performs a store.
- `HALT_XM`  in  1  instruction in EX/MEM is HALT.
- `mem_stall`  in  1  memory cannot accept a request this cycle.
- `mem_done`  in  1  the outstanding or just-issued access completes this cycle; read data is valid.
- `mem_err`  in  1  the completing access faulted; sampled only when `mem_done`=1.
- `mem_rd`, `mem_wr`  out  1  request strobes to the data memory.
- `stall_pipe`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- `en`  out  1  MEM/WB latch enable.
- `data_en`  out  1  MEM/WB read-data register enable.
- `bubble_MWB`  out  1  when 1, MEM/WB captures zeroed control fields (regWrite, memToReg, writeR7, HALT, memRead).
- `err_data`  out  1  error flag fed into MEM/WB.
- `halted`  out  1  1 in the HALTED state.

## Operation
- States: IDLE, WAIT, HALTED. Reset state is IDLE with counter=0.
- All outputs are combinational from state and inputs. Defaults: `mem_rd`, `mem_wr`, `stall_pipe`, `data_en`, `bubble_MWB`, `err_data` = 0; `en`=1.
- IDLE, no access (`memRead_XM`=`memWrite_XM`=0): pass-through with all defaults. If `HALT_XM`=1, go to HALTED after this edge; MEM/WB captures the HALT.
- IDLE, both `memRead_XM` and `memWrite_XM` = 1: illegal request. No strobe is issued; `err_data`=1, `en`=1; go to HALTED.
- IDLE, single access: `mem_rd` or `mem_wr` = 1.
  - `mem_stall`=1: request not accepted. Drive `stall_pipe`=1, `bubble_MWB`=1, `en`=1; stay in IDLE and retry next cycle.
  - `mem_stall`=0, `mem_done`=1 (hit): complete in the same cycle. Drive `data_en`=1 (reads only), `err_data`=`mem_err`. Stay in IDLE, or go to HALTED if `mem_err` or `HALT_XM` is set.
  - `mem_stall`=0, `mem_done`=0: accepted. Drive `stall_pipe`=1, `bubble_MWB`=1; go to WAIT with counter=0.
- WAIT: no strobes.
  - `mem_done`=0: drive `stall_pipe`=1, `en`=1, `bubble_MWB`=1; counter increments.
  - `mem_done`=1: drive `stall_pipe`=0, `en`=1, `bubble_MWB`=0, `data_en`=1 if the access is a read, `err_data`=`mem_err`. Go to IDLE, or to HALTED if `mem_err` or `HALT_XM` is set.
  - Timeout: counter = TO_CYCLES-1 and `mem_done`=0. Drive `err_data`=1, `en`=1, `bubble_MWB`=0, `stall_pipe`=1; go to HALTED.
- HALTED: `stall_pipe`=1, `en`=0, `halted`=1, no strobes. Exit only via reset.
- The read/write kind is taken from `memRead_XM`/`memWrite_XM`, which are held stable by `stall_pipe`.

## Timing
- Hit: 0 stall cycles. Miss: stall cycles equal the number of cycles from issue up to and including the cycle before `mem_done`.
- WAIT lasts at most TO_CYCLES cycles. If `mem_done` arrives in the timeout cycle, `mem_done` wins and no error is raised.
- Back-to-back accesses: the instruction following a completion is handled in IDLE on the next cycle with no dead cycle.
- `mem_err` without `mem_done` is ignored.
- Reset asserted mid-WAIT: state returns to IDLE immediately and the counter clears. The in-flight access is abandoned, and the bench must not expect `data_en` for it.
- Counter arithmetic is unsigned, CW bits, and is never allowed to wrap.

## Test plan
- Load hit: `memRead_XM`=1, `mem_done`=1 in the same cycle → `mem_rd`=1, `data_en`=1, `en`=1, `stall_pipe`=0 for exactly 1 cycle; state stays IDLE.
- Load miss with 4-cycle latency (`mem_done` on the 4th cycle after issue) → `stall_pipe`=1 and `bubble_MWB`=1 for 4 cycles, then `data_en`=1 with `stall_pipe`=0; exactly one non-bubble MEM/WB capture.
- Issue blocked: `mem_stall`=1 for 2 cycles, then accepted and hit → `mem_rd` high for 3 cycles, 2 bubbles, completion on the 3rd cycle.
- Timeout, TO_CYCLES=16: store issued, `mem_done` never asserted → `err_data`=1 in the 16th WAIT cycle; `halted`=1 from the next cycle; `en`=0 thereafter. A second run with `mem_done` in the 16th cycle → no error.
- Illegal request and mem_err: `memRead_XM`=`memWrite_XM`=1 → no strobe, `err_data`=1, HALTED. A load completing with `mem_err`=1 → `err_data`=1, `data_en`=1, then HALTED.
- Reset: `rst` pulled low during WAIT → all outputs 0 immediately; after release, state IDLE with counter 0, and a hit completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: issues data-memory strobes, stalls the pipeline on
// outstanding accesses, bubbles MEM/WB, and halts on timeout/illegal/faulted access.
module mem_access_ctrl #(
    parameter int TO_CYCLES = 16,
    parameter int CW        = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic memRead_XM,
    input  logic memWrite_XM,
    input  logic HALT_XM,
    input  logic mem_stall,
    input  logic mem_done,
    input  logic mem_err,
    output logic mem_rd,
    output logic mem_wr,
    output logic stall_pipe,
    output logic en,
    output logic data_en,
    output logic bubble_MWB,
    output logic err_data,
    output logic halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic illegal, access, timeout;

    assign illegal = memRead_XM & memWrite_XM;
    assign access  = memRead_XM ^ memWrite_XM;
    assign timeout = (cnt_q == CNT_LAST) & ~mem_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (illegal) begin
                    state_d = S_HALTED;
                end else if (access) begin
                    if (!mem_stall) begin
                        if (mem_done) begin
                            if (mem_err || HALT_XM) state_d = S_HALTED;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = '0;
                        end
                    end
                end else if (HALT_XM) begin
                    state_d = S_HALTED;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    state_d = (mem_err || HALT_XM) ? S_HALTED : S_IDLE;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = S_HALTED;
                    cnt_d   = '0;
                end else begin
                    // timeout fires before the top value, so this never wraps
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        stall_pipe = 1'b0;
        en         = 1'b1;
        data_en    = 1'b0;
        bubble_MWB = 1'b0;
        err_data   = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (illegal) begin
                    err_data = 1'b1;
                end else if (access) begin
                    mem_rd = memRead_XM;
                    mem_wr = memWrite_XM;
                    if (!mem_stall && mem_done) begin
                        data_en  = memRead_XM;
                        err_data = mem_err;
                    end else begin
                        stall_pipe = 1'b1;
                        bubble_MWB = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    data_en  = memRead_XM;
                    err_data = mem_err;
                end else if (timeout) begin
                    stall_pipe = 1'b1;
                    err_data   = 1'b1;
                end else begin
                    stall_pipe = 1'b1;
                    bubble_MWB = 1'b1;
                end
            end
            S_HALTED: begin
                stall_pipe = 1'b1;
                en         = 1'b0;
                halted     = 1'b1;
            end
            default: ;
        endcase
        // reset overrides everything, including the default-high enable
        if (!rst) begin
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            stall_pipe = 1'b0;
            en         = 1'b0;
            data_en    = 1'b0;
            bubble_MWB = 1'b0;
            err_data   = 1'b0;
            halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: single-cycle vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_mem_access_ctrl;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [5:0] in_v = '0;   // {rd, wr, halt, stall, done, err}
    logic memRead_XM, memWrite_XM, HALT_XM, mem_stall, mem_done, mem_err;
    logic mem_rd, mem_wr, stall_pipe, en, data_en, bubble_MWB, err_data, halted;
    logic [7:0] out_v;       // {rd, wr, stall, en, data_en, bubble, err, halted}

    assign {memRead_XM, memWrite_XM, HALT_XM, mem_stall, mem_done, mem_err} = in_v;
    assign out_v = {mem_rd, mem_wr, stall_pipe, en, data_en, bubble_MWB, err_data, halted};

    mem_access_ctrl #(.TO_CYCLES(TO), .CW(5)) dut (
        .clk(clk), .rst(rst),
        .memRead_XM(memRead_XM), .memWrite_XM(memWrite_XM), .HALT_XM(HALT_XM),
        .mem_stall(mem_stall), .mem_done(mem_done), .mem_err(mem_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .stall_pipe(stall_pipe), .en(en),
        .data_en(data_en), .bubble_MWB(bubble_MWB), .err_data(err_data), .halted(halted)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit m_halt = 0;
    bit m_wait = 0;
    int m_cnt  = 0;   // WAIT cycles already spent before the current one

    localparam logic [7:0] O_HALT = 8'b0010_0001;
    localparam logic [7:0] O_IDLE = 8'b0001_0000;
    localparam logic [7:0] O_WST  = 8'b0011_0100;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic step(input logic [5:0] i, input logic [7:0] e, input string nm);
        in_v = i;
        #2;
        chk(nm, out_v, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        in_v = '0;
        #1;
        chk("reset_outs", out_v, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_halt = 0; m_wait = 0; m_cnt = 0;
    endtask

    function automatic logic [7:0] ref_out(input logic [5:0] i);
        bit rd, wr, hl, st, dn, er;
        logic [7:0] o;
        {rd, wr, hl, st, dn, er} = i;
        if (m_halt) return O_HALT;
        o = O_IDLE;
        if (m_wait) begin
            if (dn) begin
                o[3] = rd; o[1] = er;
            end else if (m_cnt + 1 == TO) begin
                o[5] = 1; o[1] = 1;
            end else begin
                o[5] = 1; o[2] = 1;
            end
        end else if (rd && wr) begin
            o[1] = 1;
        end else if (rd || wr) begin
            o[7] = rd; o[6] = wr;
            if (!st && dn) begin
                o[3] = rd; o[1] = er;
            end else begin
                o[5] = 1; o[2] = 1;
            end
        end
        return o;
    endfunction

    task automatic model_next(input logic [5:0] i);
        bit rd, wr, hl, st, dn, er;
        {rd, wr, hl, st, dn, er} = i;
        if (m_halt) return;
        if (m_wait) begin
            if (dn) begin
                m_wait = 0;
                if (er || hl) m_halt = 1;
            end else if (m_cnt + 1 == TO) begin
                m_wait = 0; m_halt = 1;
            end else begin
                m_cnt++;
            end
        end else if (rd && wr) begin
            m_halt = 1;
        end else if (rd || wr) begin
            if (!st) begin
                if (dn) begin
                    if (er || hl) m_halt = 1;
                end else begin
                    m_wait = 1; m_cnt = 0;
                end
            end
        end else if (hl) begin
            m_halt = 1;
        end
    endtask

    typedef struct {
        string      nm;
        logic [5:0] in;
        logic [7:0] exp;
        logic [7:0] exp_next;  // outputs on the following cycle with idle inputs
    } vec_t;

    vec_t vt[11];

    initial begin
        logic [5:0] i, prev;
        logic [7:0] e;
        bit hold;
        int hcnt;

        vt[0]  = '{"idle",        6'b000000, 8'b0001_0000, O_IDLE};
        vt[1]  = '{"halt_noacc",  6'b001000, 8'b0001_0000, O_HALT};
        vt[2]  = '{"illegal",     6'b110000, 8'b0001_0010, O_HALT};
        vt[3]  = '{"rd_hit",      6'b100010, 8'b1001_1000, O_IDLE};
        vt[4]  = '{"wr_hit",      6'b010010, 8'b0101_0000, O_IDLE};
        vt[5]  = '{"rd_blocked",  6'b100100, 8'b1011_0100, O_IDLE};
        vt[6]  = '{"rd_accept",   6'b100000, 8'b1011_0100, O_WST};
        vt[7]  = '{"rd_hit_err",  6'b100011, 8'b1001_1010, O_HALT};
        vt[8]  = '{"wr_hit_halt", 6'b011010, 8'b0101_0000, O_HALT};
        vt[9]  = '{"err_nodone",  6'b100101, 8'b1011_0100, O_IDLE};
        vt[10] = '{"stall_done",  6'b100110, 8'b1011_0100, O_IDLE};

        do_reset();
        for (int k = 0; k < 11; k++) begin
            step(vt[k].in, vt[k].exp, vt[k].nm);
            step(6'b000000, vt[k].exp_next, {vt[k].nm, "_next"});
            do_reset();
        end

        // load miss, done on the 4th cycle after issue
        step(6'b100000, 8'b1011_0100, "miss_issue");
        for (int k = 0; k < 3; k++) step(6'b100000, O_WST, "miss_wait");
        step(6'b100010, 8'b0001_1000, "miss_done");
        step(6'b000000, O_IDLE, "miss_after");

        // issue blocked twice, then accepted and hit
        step(6'b100100, 8'b1011_0100, "blk_1");
        step(6'b100100, 8'b1011_0100, "blk_2");
        step(6'b100010, 8'b1001_1000, "blk_hit");
        // back-to-back store hit with no dead cycle
        step(6'b010010, 8'b0101_0000, "b2b_wr");

        // store timeout
        step(6'b010000, 8'b0111_0100, "to_issue");
        for (int k = 0; k < TO - 1; k++) step(6'b010000, O_WST, "to_wait");
        step(6'b010000, 8'b0011_0010, "to_fire");
        step(6'b010000, O_HALT, "to_halted");
        step(6'b010010, O_HALT, "to_halted2");
        do_reset();

        // done arriving in the timeout cycle wins
        step(6'b010000, 8'b0111_0100, "to2_issue");
        for (int k = 0; k < TO - 1; k++) step(6'b010000, O_WST, "to2_wait");
        step(6'b010010, O_IDLE, "to2_done");
        step(6'b000000, O_IDLE, "to2_after");

        // faulted load completing from WAIT
        step(6'b100000, 8'b1011_0100, "err_issue");
        step(6'b100011, 8'b0001_1010, "err_done");
        step(6'b000000, O_HALT, "err_halted");
        do_reset();

        // reset during WAIT
        step(6'b100000, 8'b1011_0100, "rw_issue");
        step(6'b100000, O_WST, "rw_wait");
        in_v = 6'b100000;
        #2;
        rst = 1'b0;
        #1;
        chk("rw_reset_outs", out_v, 8'h00);
        @(posedge clk);
        #1;
        chk("rw_reset_hold", out_v, 8'h00);
        rst = 1'b1;
        m_halt = 0; m_wait = 0; m_cnt = 0;
        step(6'b100010, 8'b1001_1000, "rw_hit");
        // full-length miss after reset proves the counter restarted
        step(6'b100000, 8'b1011_0100, "rw2_issue");
        for (int k = 0; k < TO - 1; k++) step(6'b100000, O_WST, "rw2_wait");
        step(6'b100010, 8'b0001_1000, "rw2_done");

        // randomized traffic against the model
        do_reset();
        hold = 0; prev = '0; hcnt = 0;
        for (int n = 0; n < 2000; n++) begin
            int r;
            int dn_pct;
            if (m_halt) hcnt++; else hcnt = 0;
            if (hcnt > 2) begin
                do_reset();
                hold = 0; hcnt = 0;
            end
            if (hold) begin
                i[5:3] = prev[5:3];
            end else begin
                r = $urandom_range(99);
                if (r < 2)       i[5:3] = 3'b110;
                else if (r < 5)  i[5:3] = 3'b001;
                else if (r < 45) i[5:3] = 3'b100;
                else if (r < 85) i[5:3] = 3'b010;
                else             i[5:3] = 3'b000;
                if (i[4:3] != 2'b00 && $urandom_range(99) < 3) i[3] = 1'b1;
            end
            dn_pct = ((n / 300) % 2 == 1) ? 4 : 40;
            i[2] = ($urandom_range(99) < 30);
            i[1] = ($urandom_range(99) < dn_pct);
            i[0] = ($urandom_range(99) < 20);
            e = ref_out(i);
            model_next(i);
            step(i, e, "random");
            hold = e[5] && !e[0];
            prev = i;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
